fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
// PURPOSE
// - Decoupling FIFO between the instruction-fetch stage and decode.
// - Buffers fetched {pc, pc_next, inst} tuples so a decode stall does not stall the imem
//   request stream.
// - Flushes all buffered entries on a control-flow redirect.
// - Downstream of fetch; its dequeue side drives the IF/ID pipeline register.
// PARAMETERS
// - DEPTH  4   entry count; power of two, >= 2
// - XLEN   32  width of pc, pc_next and inst
// PORTS
// - clk          in   1              rising-edge clock
// - rst_n        in   1              asynchronous active-low reset
// - enq_valid    in   1              fetch presents a completed instruction (imem_resp)
// - enq_pc       in   XLEN           pc of fetched instruction
// - enq_pc_next  in   XLEN           predicted next pc
// - enq_inst     in   XLEN           instruction word
// - enq_ready    out  1              queue can accept an entry this cycle
// - deq_valid    out  1              head entry is valid
// - deq_pc       out  XLEN           head pc
// - deq_pc_next  out  XLEN           head pc_next
// - deq_inst     out  XLEN           head instruction
// - deq_ready    in   1              decode consumes head this cycle (~global_stall && ~load_hazard)
// - flush        in   1              redirect; discard all entries
// - count        out  $clog2(DEPTH)+1  current occupancy
// BEHAVIOUR
// - Reset (rst_n=0, async): wr_ptr=rd_ptr=0, count=0, deq_valid=0, enq_ready=1.
//   - deq_pc/deq_pc_next/deq_inst = 0.
//   - Storage array need not be cleared.
// - Handshakes:
//   - enq fires iff enq_valid && enq_ready.
//   - deq fires iff deq_valid && deq_ready.
//   - No data change while deq_valid && !deq_ready.
// - Ready/valid derivation:
//   - enq_ready = (count != DEPTH); depends only on state, not on deq_ready.
//     When full, enqueue is refused even if a dequeue fires in the same cycle.
//   - deq_valid = (count != 0) && !flush.
// - Pointers: log2(DEPTH) bits; increment on fire; wrap DEPTH-1 -> 0 naturally.
// - Count update:
//   - Next count = count + enq_fire - deq_fire.
//   - Simultaneous enq+deq with 0 < count < DEPTH leaves count unchanged.
// - Latency: entry enqueued in cycle N is visible at head no earlier than cycle N+1
//   (unless bypass is enabled, see CONFIGURATION).
// - Ordering: strict FIFO; head outputs read combinationally from storage[rd_ptr].
// - Flush has priority over everything:
//   - In the flush cycle, enq and deq are both discarded and deq_valid is forced 0.
//   - Next cycle: count=0, wr_ptr=rd_ptr=0.
// - Full/empty:
//   - count==DEPTH -> enq_ready=0.
//   - count==0 -> deq_valid=0; deq_* hold their last driven value (don't-care).
// - Reset mid-operation: immediate return to reset state; in-flight entries lost.
// - Assertions (sim only): count <= DEPTH; no enq_fire when count==DEPTH;
//   no deq_fire when count==0.
// CONFIGURATION
// - FETCH_QUEUE_BYPASS_EN defined:
//   - Empty queue && enq_valid && deq_ready && !flush: entry passes enq->deq combinationally
//     in the same cycle and is not stored (count stays 0).
//   - deq_valid=1 and deq_* = enq_* that cycle.
//   - Empty queue with deq_ready=0: entry is stored normally.
// - Undefined: no combinational enq->deq path; minimum latency 1 cycle.
// TESTING
// - Reset:
//   - Assert rst_n=0 mid-cycle -> immediately count=0, deq_valid=0, enq_ready=1.
// - Fill:
//   - deq_ready=0; enqueue pc=0x1000,0x1004,0x1008,0x100C -> count=4, enq_ready=0.
//   - 5th enq_valid is ignored; head deq_pc=0x1000.
// - Drain in order:
//   - From full, deq_ready=1 for 4 cycles -> deq_pc 0x1000,0x1004,0x1008,0x100C;
//     then deq_valid=0, count=0.
// - Simultaneous:
//   - count=2, enq(pc=0x2000)+deq same cycle -> count stays 2.
//   - Entry 0x2000 appears after the two older entries.
//   - Repeat for 10 cycles to exercise pointer wrap.
// - Flush priority:
//   - count=3, flush=1 with enq_valid=1 and deq_ready=1 -> deq_valid=0 that cycle.
//   - Next cycle count=0; the enqueued entry is absent.
// - Bypass (FETCH_QUEUE_BYPASS_EN):
//   - Empty, enq pc=0x3000, inst=0x00000013, deq_ready=1 -> same cycle deq_valid=1,
//     deq_inst=0x00000013, count stays 0.
//   - Without the macro: deq_valid rises the next cycle instead.

Source files
------------

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: ready/valid bundle between instruction fetch and the fetch queue.
//   master : fetch side (drives enq_*, deq_ready, flush; observes the rest)
//   slave  : the queue itself
// Signals:
//   enq_valid/enq_pc/enq_pc_next/enq_inst/enq_ready  enqueue handshake + payload
//   deq_valid/deq_pc/deq_pc_next/deq_inst/deq_ready  dequeue handshake + payload
//   flush                                             redirect, discards all entries
//   count                                             current occupancy
interface fetch_queue_if #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic            enq_valid;
    logic [XLEN-1:0] enq_pc;
    logic [XLEN-1:0] enq_pc_next;
    logic [XLEN-1:0] enq_inst;
    logic            enq_ready;
    logic            deq_valid;
    logic [XLEN-1:0] deq_pc;
    logic [XLEN-1:0] deq_pc_next;
    logic [XLEN-1:0] deq_inst;
    logic            deq_ready;
    logic            flush;
    logic [CW-1:0]   count;

    modport master (
        output enq_valid, enq_pc, enq_pc_next, enq_inst, deq_ready, flush,
        input  enq_ready, deq_valid, deq_pc, deq_pc_next, deq_inst, count
    );

    modport slave (
        input  enq_valid, enq_pc, enq_pc_next, enq_inst, deq_ready, flush,
        output enq_ready, deq_valid, deq_pc, deq_pc_next, deq_inst, count
    );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: decoupling FIFO between instruction fetch and decode. Buffers
// {pc, pc_next, inst} tuples so a decode stall does not stall the imem request
// stream; a flush (redirect) discards every buffered entry.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    fetch_queue_if.slave (enq/deq handshakes, flush, count)
// Optional feature macro: FETCH_QUEUE_BYPASS_EN
//   When defined, an entry arriving at an empty queue while decode is ready
//   passes straight to the dequeue side in the same cycle and is not stored.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    fetch_queue_if.slave       bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [XLEN-1:0] mem_pc      [DEPTH];
    logic [XLEN-1:0] mem_pc_next [DEPTH];
    logic [XLEN-1:0] mem_inst    [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count_q;

    logic full;
    logic empty;
    logic enq_fire;
    logic bypass;
    logic stored_valid;
    logic push_fire;
    logic pop_fire;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // enq_ready depends only on occupancy; a full queue refuses even when a
    // dequeue fires in the same cycle.
    assign bus.enq_ready = !full;
    assign enq_fire      = bus.enq_valid && !full;

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass = empty && bus.enq_valid && bus.deq_ready && !bus.flush;
`else
    assign bypass = 1'b0;
`endif

    assign stored_valid  = !empty && !bus.flush;
    assign bus.deq_valid = stored_valid || bypass;

    // A bypassed entry is consumed directly and never touches storage.
    assign pop_fire  = stored_valid && bus.deq_ready;
    assign push_fire = enq_fire && !bus.flush && !bypass;

    assign bus.count = count_q;

    // Head is read combinationally; zero when nothing is stored so the
    // outputs are defined out of reset.
    always_comb begin
        bus.deq_pc      = '0;
        bus.deq_pc_next = '0;
        bus.deq_inst    = '0;
        if (bypass) begin
            bus.deq_pc      = bus.enq_pc;
            bus.deq_pc_next = bus.enq_pc_next;
            bus.deq_inst    = bus.enq_inst;
        end else if (!empty) begin
            bus.deq_pc      = mem_pc[rd_ptr];
            bus.deq_pc_next = mem_pc_next[rd_ptr];
            bus.deq_inst    = mem_inst[rd_ptr];
        end
    end

    // Pointers are PW bits wide so DEPTH-1 -> 0 wraps for free (DEPTH is a
    // power of two).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (bus.flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push_fire) wr_ptr <= wr_ptr + 1'b1;
            if (pop_fire)  rd_ptr <= rd_ptr + 1'b1;
            count_q <= count_q + CW'(push_fire) - CW'(pop_fire);
        end
    end

    always_ff @(posedge clk) begin
        if (push_fire) begin
            mem_pc[wr_ptr]      <= bus.enq_pc;
            mem_pc_next[wr_ptr] <= bus.enq_pc_next;
            mem_inst[wr_ptr]    <= bus.enq_inst;
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst_n) begin
            assert (count_q <= CW'(DEPTH))
                else $error("fetch_queue: count exceeds DEPTH");
            assert (!(bus.enq_valid && bus.enq_ready && full))
                else $error("fetch_queue: enqueue accepted while full");
            assert (!(pop_fire && empty))
                else $error("fetch_queue: dequeue from empty storage");
        end
    end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_next;
        logic [XLEN-1:0] inst;
    } ent_t;

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_bad;
    ent_t sb[$];

    fetch_queue_if #(.DEPTH(DEPTH), .XLEN(XLEN)) fq_if ();

    fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (fq_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        fq_if.enq_valid   = 1'b0;
        fq_if.enq_pc      = '0;
        fq_if.enq_pc_next = '0;
        fq_if.enq_inst    = '0;
        fq_if.deq_ready   = 1'b0;
        fq_if.flush       = 1'b0;
    endtask

    // One clock cycle: drive at negedge, check settled outputs, update model.
    task automatic step(input logic ev, input logic [XLEN-1:0] pc, input logic [XLEN-1:0] pn,
                        input logic [XLEN-1:0] inst, input logic dr, input logic fl);
        int   n;
        logic bp;
        logic exp_vld;
        @(negedge clk);
        fq_if.enq_valid   = ev;
        fq_if.enq_pc      = pc;
        fq_if.enq_pc_next = pn;
        fq_if.enq_inst    = inst;
        fq_if.deq_ready   = dr;
        fq_if.flush       = fl;
        #1;
        n = sb.size();
`ifdef FETCH_QUEUE_BYPASS_EN
        bp = (n == 0) && ev && dr && !fl;
`else
        bp = 1'b0;
`endif
        exp_vld = bp || ((n != 0) && !fl);
        check_val("count", 64'(fq_if.count), 64'(n));
        check_val("enq_ready", 64'(fq_if.enq_ready), 64'(n != DEPTH));
        check_val("deq_valid", 64'(fq_if.deq_valid), 64'(exp_vld));
        if (bp) begin
            check_val("byp_pc", 64'(fq_if.deq_pc), 64'(pc));
            check_val("byp_pc_next", 64'(fq_if.deq_pc_next), 64'(pn));
            check_val("byp_inst", 64'(fq_if.deq_inst), 64'(inst));
        end else if (exp_vld) begin
            check_val("head_pc", 64'(fq_if.deq_pc), 64'(sb[0].pc));
            check_val("head_pc_next", 64'(fq_if.deq_pc_next), 64'(sb[0].pc_next));
            check_val("head_inst", 64'(fq_if.deq_inst), 64'(sb[0].inst));
        end
        if (fl) begin
            sb.delete();
        end else begin
            if (exp_vld && dr && !bp) void'(sb.pop_front());
            if (ev && (n != DEPTH) && !bp) sb.push_back('{pc: pc, pc_next: pn, inst: inst});
        end
    endtask

    // Asynchronous reset asserted mid-cycle; effect must be immediate.
    task automatic mid_reset();
        idle_inputs();
        rst_n = 1'b0;
        #1;
        check_val("rst_count", 64'(fq_if.count), 64'd0);
        check_val("rst_deq_valid", 64'(fq_if.deq_valid), 64'd0);
        check_val("rst_enq_ready", 64'(fq_if.enq_ready), 64'd1);
        check_val("rst_deq_pc", 64'(fq_if.deq_pc), 64'd0);
        sb.delete();
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        rst_n   = 1'b1;
        idle_inputs();
        #2;
        mid_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Fill with decode stalled, then a refused 5th entry.
        for (int i = 0; i < DEPTH; i++)
            step(1'b1, 32'h1000 + 32'(4 * i), 32'h1004 + 32'(4 * i), 32'hA000_0000 + 32'(i), 1'b0, 1'b0);
        step(1'b1, 32'h1010, 32'h1014, 32'hDEAD_BEEF, 1'b0, 1'b0);

        // Drain in order, then confirm empty.
        for (int i = 0; i < DEPTH; i++)
            step(1'b0, '0, '0, '0, 1'b1, 1'b0);
        step(1'b0, '0, '0, '0, 1'b1, 1'b0);

        // Two entries, then simultaneous enq+deq across pointer wrap.
        step(1'b1, 32'h1800, 32'h1804, 32'h11, 1'b0, 1'b0);
        step(1'b1, 32'h1804, 32'h1808, 32'h22, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++)
            step(1'b1, 32'h2000 + 32'(4 * i), 32'h2004 + 32'(4 * i), 32'hB000_0000 + 32'(i), 1'b1, 1'b0);

        // Third entry, then flush with enq and deq both requested.
        step(1'b1, 32'h2800, 32'h2804, 32'h33, 1'b0, 1'b0);
        step(1'b1, 32'h2900, 32'h2904, 32'h44, 1'b1, 1'b1);
        step(1'b0, '0, '0, '0, 1'b1, 1'b0);

        // Empty queue with decode ready: bypass or one-cycle latency.
        step(1'b1, 32'h3000, 32'h3004, 32'h0000_0013, 1'b1, 1'b0);
        step(1'b0, '0, '0, '0, 1'b1, 1'b0);
        step(1'b0, '0, '0, '0, 1'b1, 1'b0);
        // Empty queue with decode stalled: always stored.
        step(1'b1, 32'h3100, 32'h3104, 32'h0000_0093, 1'b0, 1'b0);
        step(1'b0, '0, '0, '0, 1'b1, 1'b0);

        // Reset in the middle of traffic.
        step(1'b1, 32'h4000, 32'h4004, 32'h55, 1'b0, 1'b0);
        step(1'b1, 32'h4004, 32'h4008, 32'h66, 1'b0, 1'b0);
        mid_reset();
        step(1'b0, '0, '0, '0, 1'b1, 1'b0);

        // Random traffic with occasional flushes.
        for (int i = 0; i < 300; i++)
            step(($urandom_range(3) != 0), $urandom, $urandom, $urandom,
                 $urandom_range(1) == 1, $urandom_range(15) == 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
